// File: rtl/mem_responder_pkg.sv
// Shared state encodings and access-size constants for the byte-sequential memory responder.
`timescale 1ns/1ps
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } memState;

  localparam int BYTES_WORD = 8;
  localparam int BYTES_HALF = 4;

  // Counter value of the final byte for a given access size.
  function automatic logic [3:0] lastByteIndex(input logic half);
    return half ? 4'(BYTES_HALF - 1) : 4'(BYTES_WORD - 1);
  endfunction

endpackage

// File: rtl/mem_responder_byte_ram.sv
// Single-port byte storage: asynchronous read, synchronous write.
`timescale 1ns/1ps
module byte_ram #(
  parameter int ADDRESS_SIZE = 11,
  parameter int MEM_BYTES    = 2048
) (
  input  logic                    clk,
  input  logic                    writeEnable,
  input  logic [ADDRESS_SIZE-1:0] address,
  input  logic [7:0]              writeData,
  output logic [7:0]              readData
);

  logic [7:0] ram_memory [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (writeEnable) begin
      ram_memory[address] <= writeData;
    end
  end

  assign readData = ram_memory[address];

endmodule

// File: rtl/mem_responder.sv
// Handshaked memory responder: one request at a time, one big-endian byte access per cycle.
`timescale 1ns/1ps
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDRESS_SIZE = 11,
  parameter int WORD_SIZE    = 64,
  parameter int MEM_BYTES    = 2048
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    reqWrite,
  input  logic                    reqHalf,
  input  logic [ADDRESS_SIZE-1:0] reqAddress,
  input  logic [WORD_SIZE-1:0]    reqWriteData,
  output logic                    rspValid,
  input  logic                    rspReady,
  output logic [WORD_SIZE-1:0]    rspData,
  output logic                    rspError
);

  localparam logic [ADDRESS_SIZE:0] MEM_LIMIT = (ADDRESS_SIZE+1)'(MEM_BYTES);

  memState                 stateReg;
  logic [ADDRESS_SIZE-1:0] addrReg;
  logic                    writeReg;
  logic                    halfReg;
  logic [WORD_SIZE-1:0]    storeReg;
  logic [WORD_SIZE-1:0]    accReg;
  logic [3:0]              countReg;

  logic [3:0]              reqCount;
  logic [ADDRESS_SIZE:0]   reqEnd;
  logic                    misaligned;
  logic                    reqError;
  logic [ADDRESS_SIZE-1:0] ramAddress;
  logic [7:0]              ramReadData;
  logic                    ramWrite;
  logic [WORD_SIZE-1:0]    accNext;

  assign reqCount   = reqHalf ? 4'(BYTES_HALF) : 4'(BYTES_WORD);
  assign reqEnd     = {1'b0, reqAddress} + (ADDRESS_SIZE+1)'(reqCount);
  assign misaligned = reqHalf ? (reqAddress[1:0] != 2'b00) : (reqAddress[2:0] != 3'b000);
  assign reqError   = misaligned || (reqEnd > MEM_LIMIT);

  assign ramAddress = addrReg + ADDRESS_SIZE'(countReg);
  // A reset edge must not complete a pending store byte.
  assign ramWrite   = rst_n && (stateReg == ACCESS) && writeReg;
  assign accNext    = {accReg[WORD_SIZE-9:0], ramReadData};

  byte_ram #(
    .ADDRESS_SIZE(ADDRESS_SIZE),
    .MEM_BYTES   (MEM_BYTES)
  ) byteRam (
    .clk        (clk),
    .writeEnable(ramWrite),
    .address    (ramAddress),
    .writeData  (storeReg[WORD_SIZE-1 -: 8]),
    .readData   (ramReadData)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      reqReady <= 1'b1;
      rspValid <= 1'b0;
      rspData  <= '0;
      rspError <= 1'b0;
      addrReg  <= '0;
      writeReg <= 1'b0;
      halfReg  <= 1'b0;
      storeReg <= '0;
      accReg   <= '0;
      countReg <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (reqValid) begin
            addrReg  <= reqAddress;
            writeReg <= reqWrite;
            halfReg  <= reqHalf;
            // Left-justify store data so the next byte out is always the top byte.
            storeReg <= reqHalf ? (reqWriteData << (WORD_SIZE - 32)) : reqWriteData;
            accReg   <= '0;
            countReg <= '0;
            reqReady <= 1'b0;
            if (reqError) begin
              stateReg <= RESPOND;
              rspValid <= 1'b1;
              rspError <= 1'b1;
              rspData  <= '0;
            end else begin
              stateReg <= ACCESS;
            end
          end
        end
        ACCESS: begin
          accReg   <= accNext;
          storeReg <= storeReg << 8;
          countReg <= countReg + 4'd1;
          if (countReg == lastByteIndex(halfReg)) begin
            stateReg <= RESPOND;
            rspValid <= 1'b1;
            rspError <= 1'b0;
            rspData  <= writeReg ? '0 : accNext;
          end
        end
        RESPOND: begin
          if (rspReady) begin
            stateReg <= IDLE;
            rspValid <= 1'b0;
            reqReady <= 1'b1;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: shadow memory predicts each response and its latency.
`timescale 1ns/1ps
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic        reqHalf = 1'b0;
  logic [10:0] reqAddress = '0;
  logic [63:0] reqWriteData = '0;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [63:0] rspData;
  logic        rspError;

  int assertions = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] data;
    logic        error;
    int          latency;
  } expT;

  expT        sb[$];
  logic [7:0] shadow [2048];

  always #5 clk = ~clk;

  mem_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqWrite    (reqWrite),
    .reqHalf     (reqHalf),
    .reqAddress  (reqAddress),
    .reqWriteData(reqWriteData),
    .rspValid    (rspValid),
    .rspReady    (rspReady),
    .rspData     (rspData),
    .rspError    (rspError)
  );

  // Predict the response, update the shadow memory, then present and hand over one request.
  task automatic send(input logic w, input logic h, input int addr, input logic [63:0] data);
    expT e;
    int n;
    int guard;
    logic [63:0] d;
    n = h ? 4 : 8;
    d = h ? {32'h0, data[31:0]} : data;
    e.error = ((addr % n) != 0) || (addr + n > 2048);
    e.latency = e.error ? 0 : n;
    e.data = '0;
    if (!e.error) begin
      for (int i = 0; i < n; i++) begin
        if (w) shadow[addr + i] = 8'(d >> (8 * (n - 1 - i)));
        else   e.data = (e.data << 8) | 64'(shadow[addr + i]);
      end
    end
    sb.push_back(e);
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = w;
    reqHalf = h;
    reqAddress = 11'(addr);
    reqWriteData = data;
    guard = 0;
    while (!reqReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    assertions++;
    if (!reqReady) begin
      failures++;
      $display("FAIL accept_timeout: reqReady=%0b required 1", reqReady);
    end
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    reqWriteData = ~data;
  endtask

  task automatic waitRsp(output logic [63:0] d, output logic e, output int edges);
    edges = 0;
    while (!rspValid && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!rspValid) edges = -1;
    d = rspData;
    e = rspError;
  endtask

  task automatic ackRsp();
    rspReady = 1'b1;
    @(posedge clk);
    #1;
    rspReady = 1'b0;
  endtask

  // One scoreboard transaction: send, wait, pop the prediction and compare.
  task automatic transact(input string name, input logic w, input logic h, input int addr,
                          input logic [63:0] data);
    logic [63:0] d;
    logic e;
    int edges;
    expT x;
    send(w, h, addr, data);
    waitRsp(d, e, edges);
    x = sb.pop_front();
    assertions += 3;
    if (d !== x.data) begin
      failures++;
      $display("FAIL %s_data: got %h required %h", name, d, x.data);
    end
    if (e !== x.error) begin
      failures++;
      $display("FAIL %s_error: got %b required %b", name, e, x.error);
    end
    if (edges != x.latency) begin
      failures++;
      $display("FAIL %s_latency: got %0d edges required %0d", name, edges, x.latency);
    end
    $display("txn %s w=%0b h=%0b addr=%h data=%h err=%b edges=%0d", name, w, h, addr[10:0], d, e, edges);
    ackRsp();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    assertions++;
    if (reqReady !== 1'b1 || rspValid !== 1'b0 || rspData !== 64'h0 || rspError !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b valid=%b data=%h err=%b required 1 0 0 0",
               reqReady, rspValid, rspData, rspError);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_word_load();
    transact("preload_word", 1'b1, 1'b0, 'h000, 64'h0123456789ABCDEF);
    transact("word_load", 1'b0, 1'b0, 'h000, 64'h0);
  endtask

  task automatic test_fetch();
    transact("preload_fetch", 1'b1, 1'b1, 'h400, 64'hFFFFFFFF000ABCDE);
    transact("fetch", 1'b0, 1'b1, 'h400, 64'h0);
  endtask

  task automatic test_store_load();
    logic [7:0] b;
    transact("store8", 1'b1, 1'b0, 'h008, 64'hDEADBEEFCAFEF00D);
    b = dut.byteRam.ram_memory[8];
    assertions++;
    if (b !== 8'hDE) begin
      failures++;
      $display("FAIL ram_byte8: got %h required de", b);
    end
    b = dut.byteRam.ram_memory[15];
    assertions++;
    if (b !== 8'h0D) begin
      failures++;
      $display("FAIL ram_byte15: got %h required 0d", b);
    end
    transact("load8", 1'b0, 1'b0, 'h008, 64'h0);
  endtask

  task automatic test_errors();
    transact("err_misaligned_word", 1'b0, 1'b0, 'h004, 64'h0);
    transact("err_top_word", 1'b0, 1'b0, 'h7FC, 64'h0);
    transact("err_misaligned_half", 1'b1, 1'b1, 'h002, 64'h1234);
    transact("store_top_half", 1'b1, 1'b1, 'h7FC, 64'h00000000A5C3F00F);
    transact("load_top_half", 1'b0, 1'b1, 'h7FC, 64'h0);
    transact("store_last_word", 1'b1, 1'b0, 'h7F8, 64'h1122334455667788);
    transact("load_last_word", 1'b0, 1'b0, 'h7F8, 64'h0);
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    logic e;
    int edges;
    expT x;
    send(1'b0, 1'b0, 'h000, 64'h0);
    waitRsp(d, e, edges);
    x = sb.pop_front();
    assertions++;
    if (d !== x.data || edges != x.latency) begin
      failures++;
      $display("FAIL bp_first: got %h/%0d required %h/%0d", d, edges, x.data, x.latency);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      assertions++;
      if (rspValid !== 1'b1 || rspData !== x.data || reqReady !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h ready=%b required 1 %h 0",
                 i, rspValid, rspData, reqReady, x.data);
      end
    end
    $display("txn backpressure held 5 cycles data=%h", rspData);
    ackRsp();
    assertions++;
    if (reqReady !== 1'b1 || rspValid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got ready=%b valid=%b required 1 0", reqReady, rspValid);
    end
  endtask

  task automatic test_reset_mid_store();
    logic [7:0] b;
    logic [63:0] partial;
    transact("mid_preload", 1'b1, 1'b0, 'h010, 64'h1020304050607080);
    partial = 64'hA1A2A3A4A5A6A7A8;
    @(negedge clk);
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqHalf = 1'b0;
    reqAddress = 11'h010;
    reqWriteData = partial;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    assertions++;
    if (rspValid !== 1'b0 || reqReady !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_outputs: got valid=%b ready=%b required 0 1", rspValid, reqReady);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) shadow[16 + i] = 8'(partial >> (8 * (7 - i)));
    for (int i = 0; i < 8; i++) begin
      b = dut.byteRam.ram_memory[16 + i];
      assertions++;
      if (b !== shadow[16 + i]) begin
        failures++;
        $display("FAIL mid_reset_byte%0d: got %h required %h", 16 + i, b, shadow[16 + i]);
      end
    end
    $display("txn reset_mid_store addr=010 aborted after 3 bytes");
    transact("mid_reload", 1'b0, 1'b0, 'h010, 64'h0);
  endtask

  task automatic test_back_to_back();
    int addr;
    logic [63:0] data;
    for (int i = 0; i < 6; i++) begin
      addr = 'h100 + 8 * $urandom_range(0, 15);
      data = {$urandom, $urandom};
      transact("b2b_store", 1'b1, 1'b0, addr, data);
      transact("b2b_load", 1'b0, 1'b0, addr, 64'h0);
      transact("b2b_half", 1'b0, 1'b1, addr + 4, 64'h0);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_fetch();
    test_store_load();
    test_errors();
    test_backpressure();
    test_reset_mid_store();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at 500us, required completion");
    $fatal(1, "timeout");
  end

endmodule
